uart_cmd_rx: RTL and testbench

- UART receiver plus command-frame decoder on the host-to-chip direction: receives bytes on `rx` (ui_in[5]) and returns the `osc_sel`/`sum_sel` configuration and a measurement-start strobe to the sensor core.
- Counterpart of the existing count-reporting UART transmitter on `tx` (uo_out[0]); same 8N1 format and bit rate.
- Sits inside the top level, between the `ui_in` pad and the oscillator-select/summation logic.

---
 rtl/uart_cmd_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with A5/CMD/ARG/CHK command-frame decoder.
// Optional error counter enabled by UART_CMD_ERR_CNT_EN.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [1:0] osc_sel,
    output logic [2:0] sum_sel,
    output logic       meas_start,
    output logic       cmd_err,
    output logic [7:0] err_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [1:0] {D_HDR, D_CMD, D_ARG, D_CHK} dstate_t;

    bstate_t bstate;
    dstate_t dstate;

    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          brk;
    logic [7:0]    cmd_q, arg_q;
    logic [TW-1:0] tcnt;
    logic          stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign stop_bad = (bstate == B_STOP) && !brk && (cnt == LAST) && !rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate    <= B_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            brk       <= 1'b0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (bstate)
                B_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        bstate <= B_START;
                        cnt    <= '0;
                    end
                end
                B_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        bstate  <= rx_s2 ? B_IDLE : B_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            bstate <= B_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_STOP: begin
                    // brk holds us here through a break until the line recovers
                    if (brk) begin
                        if (rx_s2) begin
                            brk    <= 1'b0;
                            bstate <= B_IDLE;
                        end
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s2) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                            bstate   <= B_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate     <= D_HDR;
            cmd_q      <= '0;
            arg_q      <= '0;
            tcnt       <= '0;
            osc_sel    <= '0;
            sum_sel    <= '0;
            meas_start <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            meas_start <= 1'b0;
            cmd_err    <= 1'b0;
            if (dstate == D_HDR || rx_valid)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
            if (stop_bad && dstate != D_HDR) begin
                cmd_err <= 1'b1;
                dstate  <= D_HDR;
            end else if (rx_valid) begin
                unique case (dstate)
                    D_HDR: if (rx_byte == 8'hA5) dstate <= D_CMD;
                    D_CMD: begin
                        cmd_q  <= rx_byte;
                        dstate <= D_ARG;
                    end
                    D_ARG: begin
                        arg_q  <= rx_byte;
                        dstate <= D_CHK;
                    end
                    D_CHK: begin
                        dstate <= D_HDR;
                        if (rx_byte == (cmd_q ^ arg_q)) begin
                            unique case (cmd_q)
                                8'h01:   osc_sel    <= arg_q[1:0];
                                8'h02:   sum_sel    <= arg_q[2:0];
                                8'h03:   meas_start <= 1'b1;
                                default: cmd_err    <= 1'b1;
                            endcase
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    default: dstate <= D_HDR;
                endcase
            end else if (dstate != D_HDR && tcnt == T_LAST) begin
                cmd_err <= 1'b1;
                dstate  <= D_HDR;
            end
        end
    end

`ifdef UART_CMD_ERR_CNT_EN
    logic [7:0] ecnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ecnt <= '0;
        else if ((frame_err || cmd_err) && ecnt != 8'hFF)
            ecnt <= ecnt + 8'd1;
    end

    assign err_count = ecnt;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: byte reception, command frames,
// framing errors, timeout, glitch rejection and mid-byte reset.
module tb_uart_cmd_rx;

    localparam int CPB  = 8;
    localparam int TOUT = 160;
`ifdef UART_CMD_ERR_CNT_EN
    localparam bit ECNT = 1'b1;
`else
    localparam bit ECNT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic [1:0] osc_sel;
    logic [2:0] sum_sel;
    logic       meas_start;
    logic       cmd_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_cerr = 0;
    int n_meas = 0;
    int n_both = 0;
    int snap = 0;
    logic [7:0] last_byte = 8'h00;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
        .osc_sel(osc_sel), .sum_sel(sum_sel), .meas_start(meas_start),
        .cmd_err(cmd_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            last_byte = rx_byte;
        end
        if (frame_err) n_ferr++;
        if (cmd_err) n_cerr++;
        if (meas_start) n_meas++;
        if (frame_err && cmd_err) n_both++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] k);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(a, 1'b1);
        send_byte(k, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_byte"}, rx_byte, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_osc"}, osc_sel, 0);
        check({tag, "_sum"}, sum_sel, 0);
        check({tag, "_meas"}, meas_start, 0);
        check({tag, "_cerr"}, cmd_err, 0);
        check({tag, "_ecnt"}, err_count, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        send_byte(8'h3C, 1'b1);
        @(negedge clk);
        check("b3c_cnt", n_valid, 1);
        check("b3c_val", last_byte, 8'h3C);
        check("b3c_ferr", n_ferr, 0);
        check("b3c_cerr", n_cerr, 0);

        send_frame(8'h01, 8'h02, 8'h03);
        check("osc_wr", osc_sel, 2);
        check("osc_cerr", n_cerr, 0);
        check("osc_nval", n_valid, 5);

        send_frame(8'h02, 8'h05, 8'h07);
        check("sum_wr", sum_sel, 5);
        check("sum_osc", osc_sel, 2);

        send_frame(8'h03, 8'h00, 8'h03);
        check("meas_one", n_meas, 1);
        send_frame(8'h03, 8'h00, 8'h04);
        check("badchk_cerr", n_cerr, 1);
        check("badchk_meas", n_meas, 1);

        send_frame(8'h07, 8'h00, 8'h07);
        check("unk_cerr", n_cerr, 2);
        check("unk_osc", osc_sel, 2);
        send_frame(8'h01, 8'hA5, 8'hA4);
        check("a5data_osc", osc_sel, 1);
        check("a5data_cerr", n_cerr, 2);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        check_zero("rst2");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        check("fe_ferr", n_ferr, 1);
        check("fe_both", n_both, 1);
        check("fe_cerr", n_cerr, 3);
        check("fe_ecnt", err_count, ECNT ? 1 : 0);
        send_frame(8'h01, 8'h03, 8'h02);
        check("fe_resync", osc_sel, 3);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (TOUT + 10) @(posedge clk);
        @(negedge clk);
        check("to_cerr", n_cerr, 4);
        send_frame(8'h01, 8'h01, 8'h00);
        check("to_osc", osc_sel, 1);
        check("to_ecnt", err_count, ECNT ? 2 : 0);

        snap = n_valid;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("gl_valid", n_valid, snap);
        check("gl_ferr", n_ferr, 1);

        rx = 1'b0;
        repeat (25 * CPB) @(posedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(posedge clk);
        @(negedge clk);
        check("brk_ferr", n_ferr, 2);
        check("brk_valid", n_valid, snap);
        check("brk_cerr", n_cerr, 4);
        check("brk_ecnt", err_count, ECNT ? 3 : 0);

        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        check_zero("rst3");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        snap = n_valid;
        send_frame(8'h02, 8'h03, 8'h01);
        check("post_sum", sum_sel, 3);
        check("post_osc", osc_sel, 0);
        check("post_nval", n_valid, snap + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
